// File: rtl/rv_timer_pkg.sv
// Shared types, register map and helpers for the rv_timer memory-mapped timer.
// The optional capture unit is enabled by defining RV_TIMER_CAPTURE_EN.
package rv_timer_pkg;

  typedef logic [31:0] u32_t;
  typedef logic [3:0]  u4_t;
  typedef logic [4:0]  u5_t;

  localparam u32_t TMR_BASE = 32'hffff_0040;

  localparam u5_t TMR_COUNT   = 5'h00;
  localparam u5_t TMR_CMP     = 5'h04;
  localparam u5_t TMR_CTRL    = 5'h08;
  localparam u5_t TMR_STATUS  = 5'h0c;
  localparam u5_t TMR_PRESC   = 5'h10;
  localparam u5_t TMR_CAPTURE = 5'h14;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_IE       = 1;
  localparam int CTRL_AUTO_CLR = 2;
  localparam int STAT_MATCH    = 0;
  localparam int STAT_CAP      = 1;

  // Replace each byte of old_v whose lane enable is set.
  function automatic u32_t byte_merge(u32_t old_v, u32_t new_v, u4_t be);
    u32_t r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rv_timer_if.sv
// Data-bus slice seen by the timer: chip select, offset, strobes and data.
interface rv_timer_if;
  import rv_timer_pkg::*;

  logic cs;
  u5_t  adr;
  logic re;
  u4_t  we;
  u32_t dw;
  u32_t dr;

  modport master (output cs, adr, re, we, dw, input dr);
  modport slave  (input cs, adr, re, we, dw, output dr);
endinterface

// File: rtl/rv_timer_presc.sv
// Prescaler: counts 0..presc_i while enabled and pulses tick_o on the terminal count.
module rv_timer_presc #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [PRESCALE_W-1:0] presc_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

  assign tick_o = en_i && (pcnt_q == presc_i);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr_i)       pcnt_d = '0;
    else if (tick_o) pcnt_d = '0;
    else if (en_i)   pcnt_d = pcnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pcnt_q <= '0;
    else       pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/rv_timer.sv
// rv_timer: prescaled 32-bit counter with compare/match, level irq and registered reads.
// Define RV_TIMER_CAPTURE_EN to add the cap_in input capture unit.
module rv_timer
  import rv_timer_pkg::*;
#(
  parameter int   PRESCALE_W = 16,
  parameter u32_t RESET_CMP  = 32'hffff_ffff
) (
  input  logic       clk,
  input  logic       reset,
  rv_timer_if.slave  bus,
`ifdef RV_TIMER_CAPTURE_EN
  input  logic       cap_in,
`endif
  output logic       irq
);

  u32_t                  count_q, count_d;
  u32_t                  cmp_q, cmp_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic                  match_q, match_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  u32_t                  dr_q, dr_d;
  u32_t                  presc_wr, rdata;
  u5_t                   word_adr;
  logic                  wr_any, wr_count, wr_cmp, wr_ctrl, wr_status, wr_presc;
  logic                  tick, hit, cap_flag, cap_clr;
  u32_t                  capture_val;
  logic                  unused_bits;

  rv_timer_presc #(.PRESCALE_W(PRESCALE_W)) u_presc (
    .clk     (clk),
    .reset   (reset),
    .en_i    (ctrl_q[CTRL_EN]),
    .clr_i   (wr_count | wr_presc),
    .presc_i (presc_q),
    .tick_o  (tick)
  );

  assign word_adr    = {bus.adr[4:2], 2'b00};
  assign wr_any      = bus.cs && (bus.we != 4'b0000);
  assign wr_count    = wr_any && (word_adr == TMR_COUNT);
  assign wr_cmp      = wr_any && (word_adr == TMR_CMP);
  assign wr_ctrl     = wr_any && (word_adr == TMR_CTRL);
  assign wr_status   = wr_any && (word_adr == TMR_STATUS);
  assign wr_presc    = wr_any && (word_adr == TMR_PRESC);
  assign hit         = tick && (count_q == cmp_q);
  assign cap_clr     = wr_status && bus.we[0] && bus.dw[STAT_CAP];
  assign presc_wr    = byte_merge(32'(presc_q), bus.dw, bus.we);
  assign unused_bits = ^{bus.adr[1:0], presc_wr};

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    cmp_d   = cmp_q;
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    // A bus write to COUNT wins over both increment and auto-clear.
    if (wr_count)                          count_d = byte_merge(count_q, bus.dw, bus.we);
    else if (hit && ctrl_q[CTRL_AUTO_CLR]) count_d = '0;
    else if (tick)                         count_d = count_q + 32'd1;
    if (wr_cmp)                  cmp_d   = byte_merge(cmp_q, bus.dw, bus.we);
    if (wr_ctrl && bus.we[0])    ctrl_d  = bus.dw[2:0];
    if (wr_presc)                presc_d = presc_wr[PRESCALE_W-1:0];
    // A match in the same cycle as its W1C keeps the flag set.
    match_d = hit | (match_q & ~(wr_status && bus.we[0] && bus.dw[STAT_MATCH]));
  end

  always_comb begin
    rdata = '0;
    case (word_adr)
      TMR_COUNT:   rdata = count_q;
      TMR_CMP:     rdata = cmp_q;
      TMR_CTRL:    rdata = {29'b0, ctrl_q};
      TMR_STATUS:  rdata = {30'b0, cap_flag, match_q};
      TMR_PRESC:   rdata = 32'(presc_q);
      TMR_CAPTURE: rdata = capture_val;
      default:     rdata = '0;
    endcase
    dr_d = (bus.cs && bus.re) ? rdata : dr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      cmp_q   <= RESET_CMP;
      ctrl_q  <= '0;
      match_q <= 1'b0;
      presc_q <= '0;
      dr_q    <= '0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      match_q <= match_d;
      presc_q <= presc_d;
      dr_q    <= dr_d;
    end
  end

`ifdef RV_TIMER_CAPTURE_EN
  // Two synchronizer stages plus one history stage for rising-edge detection.
  logic [2:0] cap_sync_q;
  logic       cap_q, cap_edge;
  u32_t       capture_q;

  assign cap_edge = cap_sync_q[1] & ~cap_sync_q[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_sync_q <= '0;
      cap_q      <= 1'b0;
      capture_q  <= '0;
    end else begin
      cap_sync_q <= {cap_sync_q[1:0], cap_in};
      cap_q      <= cap_edge | (cap_q & ~cap_clr);
      if (cap_edge) capture_q <= count_q;
    end
  end

  assign cap_flag    = cap_q;
  assign capture_val = capture_q;
`else
  logic unused_cap;
  assign unused_cap  = cap_clr;
  assign cap_flag    = 1'b0;
  assign capture_val = '0;
`endif

  assign bus.dr = dr_q;
  assign irq    = match_q & ctrl_q[CTRL_IE];

endmodule

// File: doc/rv_timer.md
# rv_timer

Memory-mapped timer/compare responder on the rv_core data bus (d_adr/d_re/d_we/d_dw/d_dr), decoded at 0xffff0040 alongside the serial terminal at 0xffff0020. Provides a prescaled 32-bit up-counter, a compare register with match flag, and a level interrupt request merged into the core `irq`. Read data is registered and returned one cycle after `re`, matching the existing peripheral read-mux scheme.

## Interface
- PRESCALE_W, 16, width of prescaler divisor register
- RESET_CMP, 32'hffff_ffff, reset value of compare register
- clk  in  1  core clock (cclk domain)
- reset  in  1  asynchronous, active-high reset
- cs  in  1  chip select, decoded {adr[31:5],5'h0}==32'hffff0040
- adr  in  5  byte offset within window; adr[1:0] ignored
- re  in  1  read strobe, qualified by cs
- we  in  4  byte write enables, qualified by cs
- dw  in  32  write data
- dr  out  32  read data, valid the cycle after cs&re
- irq  out  1  level interrupt: match flag & CTRL.IE
- cap_in  in  1  capture trigger (present only with RV_TIMER_CAPTURE_EN)

## Operation
- Registers (word offset): 0x00 COUNT rw; 0x04 CMP rw; 0x08 CTRL rw (bit0 EN, bit1 IE, bit2 AUTO_CLR); 0x0C STATUS (bit0 MATCH, bit1 CAP, W1C); 0x10 PRESC rw, PRESCALE_W bits; 0x14 CAPTURE ro; others read 0, writes ignored.
- Byte lanes: we[i] writes dw[8i+7:8i]; partial writes legal on all rw registers.
- Prescaler: pcnt counts 0..PRESC while EN; tick asserted when pcnt==PRESC, pcnt then returns 0. PRESC=0 -> tick every cycle.
- COUNT increments by 1 on tick, wraps 0xffffffff->0 with no flag.
- Match: on tick where COUNT==CMP, MATCH set; if AUTO_CLR, COUNT loads 0 instead of incrementing (period = (CMP+1)*(PRESC+1) cycles).
- Priority in one cycle: bus write to COUNT beats increment/auto-clear; match set beats W1C clear of MATCH (flag stays 1).
- Writing COUNT or PRESC resets pcnt to 0.
- EN=0: pcnt and COUNT hold; MATCH holds; irq still reflects MATCH&IE.
- irq is combinational from registered MATCH and IE only.
- Reset mid-operation: all registers to reset values immediately; pending read data discarded (dr=0).

## Timing
- Reset values: COUNT 0, CMP RESET_CMP, CTRL 0, STATUS 0, PRESC 0, CAPTURE 0, pcnt 0, dr 0, irq 0.
- Read latency 1: cs&re in cycle N -> dr valid in N+1, holds until next read; value is register state at end of N (before N's updates).
- Write takes effect at the clock edge ending the write cycle; read in N+1 returns new value.
- Bus never stalls: responder is always ready (core d_rdy stays 1).
- irq rises the cycle after the matching tick edge; falls the cycle after W1C of MATCH or IE clear.

## Configuration
- RV_TIMER_CAPTURE_EN defined: cap_in port exists; 2-flop synchronizer + rising-edge detect; on edge, CAPTURE<=COUNT and STATUS.CAP set (W1C); edge coincident with COUNT write captures pre-write value.
- Undefined: no cap_in port, CAPTURE and STATUS.CAP read 0, no synchronizer flops.

## Structure
- rv_types package gains: timer register offsets (TMR_COUNT..TMR_CAPTURE as u5_t constants), CTRL/STATUS bit index constants, base address 32'hffff0040.
- Uses existing u32_t/u4_t typedefs.
- One sub-module natural: rv_timer_presc (prescaler counter producing tick, with load-clear input).
- Top integration: second re1-style registered select extends the d_dr mux; irq ORed with rv_sio irq.

## Test plan
- Reset: assert reset mid-count with EN=1, COUNT=0x1234 -> all reads return reset values, irq=0, dr=0.
- PRESC=3, EN=1, COUNT=0: after 40 cycles COUNT reads 10; PRESC=0 -> increments every cycle.
- CMP=4, PRESC=0, CTRL=0b111: MATCH every 5 ticks, COUNT sequence 0..4,0; irq high 1 cycle after match; W1C STATUS=1 drops irq next cycle.
- Simultaneous W1C of MATCH and new match tick -> MATCH remains 1; write COUNT=0xffffffff, EN=1 -> wraps to 0, no MATCH unless CMP=0.
- Byte write we=4'b0100 dw=0x00ab0000 to CMP=0xffffffff -> CMP reads 0xffabffff; read of offset 0x1c returns 0.
- With RV_TIMER_CAPTURE_EN: pulse cap_in at COUNT=100, PRESC=0 -> CAPTURE reads 102 or 103 (sync latency fixed per implementation, checked exactly), STATUS.CAP=1; without macro, CAPTURE reads 0.
